// File: rtl/spi_interface.sv
`default_nettype none
// ============================================================================
// Module   : spi_interface
// Brief    : Mode-0 SPI slave, oversampled in clk, bridging 32-bit SPI words
//            to/from host2fpga / fpga2host AXI-Stream channels.
// Revision : 1.0
// ============================================================================
module spi_interface (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_cs,
  input  logic        spi_frame,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [31:0] interf_host2fpga_tdata,
  output logic        interf_host2fpga_tvalid,
  output logic        interf_host2fpga_tlast,
  input  logic        interf_host2fpga_tready,
  input  logic [31:0] interf_fpga2host_tdata,
  input  logic        interf_fpga2host_tvalid,
  input  logic        interf_fpga2host_tlast,
  output logic        interf_fpga2host_tready,
  output logic        spi_int,
  input  logic [9:0]  fpga2host_fifo_filled,
  input  logic [9:0]  host2fpga_fifo_empty,
  input  logic        err_outfifo_overflow_pulse
);

  localparam logic [7:0]  c_ESC_BYTE = 8'hE5;
  localparam logic [31:0] c_LIT_ESC  = 32'hE580_0000;

  typedef enum logic [1:0] {
    K_STATUS = 2'd0,
    K_DATA   = 2'd1,
    K_ESC    = 2'd2
  } kind_t;

  logic [1:0]  sclk_sync_q, cs_sync_q, frame_sync_q, mosi_sync_q;
  logic        sclk_prev_q, cs_prev_q;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [31:0] rx_q, rx_d;
  logic [32:0] tx_q, tx_d;
  kind_t       kind_q, kind_d;
  logic [31:0] cur_q, cur_d;
  logic        cur_err_q, cur_err_d;
  logic        pend_vld_q, pend_vld_d;
  logic        pend_esc_q, pend_esc_d;
  logic [31:0] pend_q, pend_d;
  logic        h2f_vld_q, h2f_vld_d;
  logic [31:0] h2f_q, h2f_d;
  logic        f2h_rdy_q, f2h_rdy_d;
  logic        err_q, err_d;
  logic        int_q, int_d;

  logic        w_cs_act, w_rise, w_fall, w_cs_fall, w_cs_rise;
  logic [4:0]  w_cnt;
  logic        w_done, w_load, w_overrun, w_err_clr;
  logic [31:0] w_rx_word, w_status, w_sel_word;
  logic        w_unused;

  assign w_unused  = interf_fpga2host_tlast;

  assign w_cs_act  = ~cs_sync_q[1];
  assign w_rise    = w_cs_act &  sclk_sync_q[1] & ~sclk_prev_q;
  assign w_fall    = w_cs_act & ~sclk_sync_q[1] &  sclk_prev_q;
  assign w_cs_fall =  cs_prev_q & ~cs_sync_q[1];
  assign w_cs_rise = ~cs_prev_q &  cs_sync_q[1];
  // A frame marker on this bit restarts the word count at bit 0
  assign w_cnt     = frame_sync_q[1] ? 5'd0 : bitcnt_q;
  assign w_done    = w_rise & (w_cnt == 5'd31);
  assign w_load    = w_cs_fall | w_done;
  assign w_rx_word = {rx_q[30:0], mosi_sync_q[1]};
  assign w_overrun = w_done & h2f_vld_q & ~interf_host2fpga_tready;
  assign w_err_clr = w_done & (kind_q == K_STATUS) & cur_err_q;
  assign err_d     = (err_q & ~w_err_clr) | err_outfifo_overflow_pulse | w_overrun;
  assign w_status  = {c_ESC_BYTE, 1'b0, err_d, host2fpga_fifo_empty,
                      fpga2host_fifo_filled, 2'b00};
  assign int_d     = interf_fpga2host_tvalid | err_d;

  always_comb begin
    bitcnt_d   = bitcnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    kind_d     = kind_q;
    cur_d      = cur_q;
    cur_err_d  = cur_err_q;
    pend_vld_d = pend_vld_q;
    pend_esc_d = pend_esc_q;
    pend_d     = pend_q;
    h2f_vld_d  = h2f_vld_q & ~interf_host2fpga_tready;
    h2f_d      = h2f_q;
    f2h_rdy_d  = 1'b0;
    w_sel_word = w_status;

    if (w_rise) begin
      rx_d     = w_rx_word;
      bitcnt_d = w_cnt + 5'd1;
    end
    if (w_fall) begin
      tx_d = {tx_q[31:0], 1'b0};
    end
    if (w_done && !w_overrun) begin
      h2f_vld_d = 1'b1;
      h2f_d     = w_rx_word;
    end

    if (w_load) begin
      if (pend_vld_q && pend_esc_q) begin
        w_sel_word = c_LIT_ESC;
        kind_d     = K_ESC;
        pend_esc_d = 1'b0;
      end else if (pend_vld_q) begin
        w_sel_word = pend_q;
        kind_d     = K_DATA;
        cur_d      = pend_q;
        pend_vld_d = 1'b0;
      end else if (interf_fpga2host_tvalid) begin
        f2h_rdy_d = 1'b1;
        if (interf_fpga2host_tdata[31:24] == c_ESC_BYTE) begin
          w_sel_word = c_LIT_ESC;
          kind_d     = K_ESC;
          pend_d     = interf_fpga2host_tdata;
          pend_vld_d = 1'b1;
          pend_esc_d = 1'b0;
        end else begin
          w_sel_word = interf_fpga2host_tdata;
          kind_d     = K_DATA;
          cur_d      = interf_fpga2host_tdata;
        end
      end else begin
        kind_d    = K_STATUS;
        cur_err_d = err_d;
      end
      // tx_q[32] drives MISO: at a word boundary the last bit of the current
      // word stays on the pin until the falling edge shifts the new MSB in.
      tx_d = w_cs_fall ? {w_sel_word, 1'b0} : {tx_q[32], w_sel_word};
    end

    if (w_cs_fall) begin
      bitcnt_d = 5'd0;
    end

    if (w_cs_rise) begin
      tx_d      = '0;
      bitcnt_d  = 5'd0;
      kind_d    = K_STATUS;
      cur_err_d = 1'b0;
      if (kind_q == K_DATA) begin
        pend_vld_d = 1'b1;
        pend_d     = cur_q;
        pend_esc_d = 1'b0;
      end else if (kind_q == K_ESC) begin
        pend_esc_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q  <= 2'b00;
      cs_sync_q    <= 2'b11;
      frame_sync_q <= 2'b00;
      mosi_sync_q  <= 2'b00;
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b1;
      bitcnt_q     <= 5'd0;
      rx_q         <= '0;
      tx_q         <= '0;
      kind_q       <= K_STATUS;
      cur_q        <= '0;
      cur_err_q    <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_esc_q   <= 1'b0;
      pend_q       <= '0;
      h2f_vld_q    <= 1'b0;
      h2f_q        <= '0;
      f2h_rdy_q    <= 1'b0;
      err_q        <= 1'b0;
      int_q        <= 1'b0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[0], spi_clk};
      cs_sync_q    <= {cs_sync_q[0], spi_cs};
      frame_sync_q <= {frame_sync_q[0], spi_frame};
      mosi_sync_q  <= {mosi_sync_q[0], spi_mosi};
      sclk_prev_q  <= sclk_sync_q[1];
      cs_prev_q    <= cs_sync_q[1];
      bitcnt_q     <= bitcnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      kind_q       <= kind_d;
      cur_q        <= cur_d;
      cur_err_q    <= cur_err_d;
      pend_vld_q   <= pend_vld_d;
      pend_esc_q   <= pend_esc_d;
      pend_q       <= pend_d;
      h2f_vld_q    <= h2f_vld_d;
      h2f_q        <= h2f_d;
      f2h_rdy_q    <= f2h_rdy_d;
      err_q        <= err_d;
      int_q        <= int_d;
    end
  end

  assign spi_miso                = tx_q[32];
  assign interf_host2fpga_tdata  = h2f_q;
  assign interf_host2fpga_tvalid = h2f_vld_q;
  assign interf_host2fpga_tlast  = 1'b0;
  assign interf_fpga2host_tready = f2h_rdy_q;
  assign spi_int                 = int_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_interface.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_interface
// Brief    : Directed + randomized bench for spi_interface with a word-stream
//            reference model of the MISO escape protocol.
// Revision : 1.0
// ============================================================================
module tb_spi_interface;
  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_clk = 1'b0, spi_cs = 1'b1, spi_frame = 1'b0, spi_mosi = 1'b0;
  logic        spi_miso;
  logic [31:0] h2f_tdata;
  logic        h2f_tvalid, h2f_tlast;
  logic        h2f_tready = 1'b1;
  logic [31:0] f2h_tdata = '0;
  logic        f2h_tvalid = 1'b0;
  logic        f2h_tlast = 1'b0;
  logic        f2h_tready;
  logic        spi_int;
  logic [9:0]  filled = '0, empty = '0;
  logic        errp = 1'b0;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, last_rise_cyc = 0, tv_rise_cyc = 0;
  int ready_cycles = 0, total_pushed = 0;

  logic [31:0] src_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] snk_q[$];
  logic [31:0] mosi_w[8];
  logic [31:0] miso_w[8];

  spi_interface dut (
    .clk                        (clk),
    .rst                        (rst),
    .spi_clk                    (spi_clk),
    .spi_cs                     (spi_cs),
    .spi_frame                  (spi_frame),
    .spi_mosi                   (spi_mosi),
    .spi_miso                   (spi_miso),
    .interf_host2fpga_tdata     (h2f_tdata),
    .interf_host2fpga_tvalid    (h2f_tvalid),
    .interf_host2fpga_tlast     (h2f_tlast),
    .interf_host2fpga_tready    (h2f_tready),
    .interf_fpga2host_tdata     (f2h_tdata),
    .interf_fpga2host_tvalid    (f2h_tvalid),
    .interf_fpga2host_tlast     (f2h_tlast),
    .interf_fpga2host_tready    (f2h_tready),
    .spi_int                    (spi_int),
    .fpga2host_fifo_filled      (filled),
    .host2fpga_fifo_empty       (empty),
    .err_outfifo_overflow_pulse (errp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // fpga2host FIFO model: pops on a tvalid & tready handshake
  always begin
    bit pop;
    @(negedge clk);
    pop = f2h_tvalid && f2h_tready;
    if (f2h_tready) ready_cycles++;
    @(posedge clk); #1;
    if (pop) void'(src_q.pop_front());
    f2h_tvalid = (src_q.size() != 0);
    f2h_tdata  = (src_q.size() != 0) ? src_q[0] : 32'h0;
  end

  // host2fpga sink: records accepted words and the latest tvalid rise
  always begin
    bit prev_tv;
    @(negedge clk);
    if (h2f_tvalid && h2f_tready) snk_q.push_back(h2f_tdata);
    if (h2f_tvalid && !prev_tv) tv_rise_cyc = cyc;
    prev_tv = h2f_tvalid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] stat(input logic e);
    return {8'hE5, 1'b0, e, empty, filled, 2'b00};
  endfunction

  // Expected MISO stream: E5-prefixed data is preceded by the literal escape
  task automatic push_src(input logic [31:0] w);
    src_q.push_back(w);
    total_pushed++;
    if (w[31:24] == 8'hE5) exp_q.push_back(32'hE580_0000);
    exp_q.push_back(w);
  endtask

  task automatic spi_bits(input logic [31:0] d, input int n, input bit fr,
                          output logic [31:0] m);
    m = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi  = d[31-i];
      spi_frame = fr && (i == 0);
      tick(HALF);
      m = {m[30:0], spi_miso};
      spi_clk = 1'b1;
      if (i == n - 1) last_rise_cyc = cyc;
      tick(HALF);
      spi_clk   = 1'b0;
      spi_frame = 1'b0;
    end
  endtask

  task automatic cs_begin();
    spi_cs = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_end();
    tick(HALF);
    spi_cs = 1'b1;
    tick(2 * HALF);
  endtask

  task automatic xfer(input int n);
    logic [31:0] m;
    cs_begin();
    for (int k = 0; k < n; k++) begin
      spi_bits(mosi_w[k], 32, 1'b1, m);
      miso_w[k] = m;
    end
    cs_end();
  endtask

  task automatic check_snk(input string tag, input int n);
    for (int k = 0; k < n; k++)
      chk(tag, (snk_q.size() != 0) ? snk_q.pop_front() : 32'hxxxx_xxxx, mosi_w[k]);
    chk({tag, "_extra"}, snk_q.size(), 0);
  endtask

  initial begin
    logic [31:0] m, w, w0;
    int r0;

    // Reset values
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("rst_miso", spi_miso, 0);
    chk("rst_int", spi_int, 0);
    chk("rst_tvalid", h2f_tvalid, 0);
    chk("rst_tready", f2h_tready, 0);

    // Reset asserted in the middle of a transfer
    cs_begin();
    spi_bits(32'hA5A5_0000, 10, 1'b1, m);
    rst = 1'b1;
    tick(2);
    chk("midrst_miso", spi_miso, 0);
    chk("midrst_int", spi_int, 0);
    chk("midrst_tvalid", h2f_tvalid, 0);
    rst = 1'b0;
    spi_cs = 1'b1;
    tick(2 * HALF);
    mosi_w[0] = $urandom;
    xfer(1);
    chk("midrst_miso_w", miso_w[0], 32'hE500_0000);
    check_snk("midrst_rcv", 1);

    // Plain words with idle fpga2host and zero status
    mosi_w[0] = 32'h0100_0000; mosi_w[1] = 32'h0; mosi_w[2] = 32'h0;
    xfer(3);
    for (int k = 0; k < 3; k++) chk("idle_miso", miso_w[k], 32'hE500_0000);
    chk("h2f_latency", tv_rise_cyc - last_rise_cyc, 3);
    chk("h2f_tlast", h2f_tlast, 0);
    check_snk("idle_rcv", 3);

    // Data word, then E5-prefixed data word
    r0 = ready_cycles;
    push_src(32'h1234_5678);
    push_src(32'hE512_0000);
    tick(2);
    for (int k = 0; k < 3; k++) mosi_w[k] = $urandom;
    xfer(3);
    chk("esc_miso0", miso_w[0], 32'h1234_5678);
    chk("esc_miso1", miso_w[1], 32'hE580_0000);
    chk("esc_miso2", miso_w[2], 32'hE512_0000);
    chk("esc_pops", ready_cycles - r0, 2);
    chk("esc_drained", src_q.size(), 0);
    exp_q.delete();
    check_snk("esc_rcv", 3);

    // Overflow error reported in the status word, then cleared
    filled = 10'd5;
    empty  = 10'd512;
    errp = 1'b1;
    tick(1);
    errp = 1'b0;
    tick(3);
    chk("err_int_set", spi_int, 1);
    mosi_w[0] = $urandom; mosi_w[1] = $urandom;
    xfer(2);
    chk("err_stat0", miso_w[0], 32'hE560_0014);
    chk("err_stat1", miso_w[1], 32'hE520_0014);
    chk("err_int_clr", spi_int, 0);
    check_snk("err_rcv", 2);

    // host2fpga stalled: second word dropped, error raised
    filled = '0;
    empty  = '0;
    h2f_tready = 1'b0;
    mosi_w[0] = $urandom; mosi_w[1] = $urandom;
    w0 = mosi_w[0];
    xfer(2);
    tick(2);
    chk("ovr_tvalid", h2f_tvalid, 1);
    chk("ovr_tdata", h2f_tdata, w0);
    chk("ovr_int", spi_int, 1);
    h2f_tready = 1'b1;
    tick(2);
    mosi_w[0] = w0;
    check_snk("ovr_rcv", 1);
    mosi_w[0] = $urandom;
    xfer(1);
    chk("ovr_stat", miso_w[0], 32'hE540_0000);
    chk("ovr_int_clr", spi_int, 0);
    check_snk("ovr_rcv2", 1);

    // Chip select released mid-word: popped data word is resent
    push_src(32'h0BAD_F00D);
    push_src(32'h1357_9BDF);
    tick(2);
    mosi_w[0] = $urandom;
    xfer(1);
    chk("abort_miso0", miso_w[0], exp_q.pop_front());
    check_snk("abort_rcv0", 1);
    cs_begin();
    spi_bits($urandom, 10, 1'b1, m);
    cs_end();
    chk("abort_partial_rcv", snk_q.size(), 0);
    mosi_w[0] = $urandom;
    xfer(1);
    chk("abort_resend", miso_w[0], exp_q.pop_front());
    check_snk("abort_rcv1", 1);

    // Frame marker mid-word resynchronises the word boundary
    w = $urandom;
    cs_begin();
    spi_bits($urandom, 10, 1'b1, m);
    spi_bits(w, 32, 1'b1, m);
    cs_end();
    mosi_w[0] = w;
    check_snk("frame_rcv", 1);

    // Randomized rounds against the stream model
    for (int r = 0; r < 8; r++) begin
      int nw, n;
      nw = $urandom_range(0, 3);
      n  = $urandom_range(1, 4);
      filled = 10'($urandom_range(0, 512));
      empty  = 10'($urandom_range(0, 512));
      for (int k = 0; k < nw; k++) begin
        w = $urandom;
        if ($urandom_range(0, 2) == 0) w[31:24] = 8'hE5;
        push_src(w);
      end
      for (int k = 0; k < n; k++) mosi_w[k] = $urandom;
      tick(2);
      xfer(n);
      for (int k = 0; k < n; k++)
        chk("rnd_miso", miso_w[k], (exp_q.size() != 0) ? exp_q.pop_front() : stat(1'b0));
      check_snk("rnd_rcv", n);
    end

    // Drain whatever remains in the model stream
    for (int g = 0; g < 6 && exp_q.size() != 0; g++) begin
      for (int k = 0; k < 4; k++) mosi_w[k] = $urandom;
      xfer(4);
      for (int k = 0; k < 4; k++)
        chk("drain_miso", miso_w[k], (exp_q.size() != 0) ? exp_q.pop_front() : stat(1'b0));
      check_snk("drain_rcv", 4);
    end
    tick(4);
    chk("total_pops", ready_cycles, total_pushed);
    chk("src_empty", src_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
